// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded ID-side inputs, registered EX-side outputs,
// global stall/flush controls and the hazard-unit hold signals.
interface id_ex_stage_if #(
   parameter int DW = 32,
   parameter int RW = 5
);
   logic          ext_stall, flush;
   logic          ID_valid;
   logic [RW-1:0] ID_Rs, ID_Rt, ID_Rd;
   logic          ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc, ID_RegDst;
   logic [3:0]    ID_ALUOp;
   logic [DW-1:0] ID_rs_data, ID_rt_data, ID_imm, ID_PC;
   logic          EX_valid;
   logic [RW-1:0] EX_Rs, EX_Rt, EX_Rd;
   logic          EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemtoReg, EX_ALUSrc, EX_RegDst;
   logic [3:0]    EX_ALUOp;
   logic [DW-1:0] EX_rs_data, EX_rt_data, EX_imm, EX_PC;
   logic          pc_write, IF_ID_write;
   logic [15:0]   bubble_cnt;

   // upstream side: decode stage, stall/flush sources, downstream consumers
   modport master (
      output ext_stall, flush, ID_valid, ID_Rs, ID_Rt, ID_Rd,
             ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc, ID_RegDst,
             ID_ALUOp, ID_rs_data, ID_rt_data, ID_imm, ID_PC,
      input  EX_valid, EX_Rs, EX_Rt, EX_Rd,
             EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemtoReg, EX_ALUSrc, EX_RegDst,
             EX_ALUOp, EX_rs_data, EX_rt_data, EX_imm, EX_PC,
             pc_write, IF_ID_write, bubble_cnt
   );

   // pipeline register side
   modport slave (
      input  ext_stall, flush, ID_valid, ID_Rs, ID_Rt, ID_Rd,
             ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc, ID_RegDst,
             ID_ALUOp, ID_rs_data, ID_rt_data, ID_imm, ID_PC,
      output EX_valid, EX_Rs, EX_Rt, EX_Rd,
             EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemtoReg, EX_ALUSrc, EX_RegDst,
             EX_ALUOp, EX_rs_data, EX_rt_data, EX_imm, EX_PC,
             pc_write, IF_ID_write, bubble_cnt
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// Optional load-use bubble counter: define ID_EX_BUBBLE_CNT_EN.
module id_ex_stage #(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input logic           clk,
   input logic           rst,
   id_ex_stage_if.slave  bus
);
   typedef struct packed {
      logic          valid;
      logic [RW-1:0] rs, rt, rd;
      logic          reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst;
      logic [3:0]    alu_op;
      logic [DW-1:0] rs_data, rt_data, imm, pc;
   } ex_pkt_t;

   ex_pkt_t id_pkt, ex_q;
   logic    load_use;

   // pack decoded ID fields into one payload
   always_comb begin
      id_pkt = '{valid: bus.ID_valid, rs: bus.ID_Rs, rt: bus.ID_Rt, rd: bus.ID_Rd,
                 reg_write: bus.ID_RegWrite, mem_read: bus.ID_MemRead,
                 mem_write: bus.ID_MemWrite, mem_to_reg: bus.ID_MemtoReg,
                 alu_src: bus.ID_ALUSrc, reg_dst: bus.ID_RegDst, alu_op: bus.ID_ALUOp,
                 rs_data: bus.ID_rs_data, rt_data: bus.ID_rt_data,
                 imm: bus.ID_imm, pc: bus.ID_PC};
   end

   // a load in EX whose destination feeds the instruction in ID; $zero never hazards
   assign load_use = ex_q.valid & ex_q.mem_read & (ex_q.rt != '0) & bus.ID_valid &
                     ((ex_q.rt == bus.ID_Rs) | (ex_q.rt == bus.ID_Rt));

   assign bus.pc_write    = ~(load_use | bus.ext_stall);
   assign bus.IF_ID_write = ~(load_use | bus.ext_stall);

   // pipeline register: reset > global stall > flush/load-use bubble > capture
   always_ff @(posedge clk) begin
      if (!rst)                         ex_q <= '0;
      else if (bus.ext_stall)           ex_q <= ex_q;
      else if (bus.flush || load_use)   ex_q <= '0;   // all-zero bubble, indices too
      else                              ex_q <= id_pkt;
   end

   assign bus.EX_valid    = ex_q.valid;
   assign bus.EX_Rs       = ex_q.rs;
   assign bus.EX_Rt       = ex_q.rt;
   assign bus.EX_Rd       = ex_q.rd;
   assign bus.EX_RegWrite = ex_q.reg_write;
   assign bus.EX_MemRead  = ex_q.mem_read;
   assign bus.EX_MemWrite = ex_q.mem_write;
   assign bus.EX_MemtoReg = ex_q.mem_to_reg;
   assign bus.EX_ALUSrc   = ex_q.alu_src;
   assign bus.EX_RegDst   = ex_q.reg_dst;
   assign bus.EX_ALUOp    = ex_q.alu_op;
   assign bus.EX_rs_data  = ex_q.rs_data;
   assign bus.EX_rt_data  = ex_q.rt_data;
   assign bus.EX_imm      = ex_q.imm;
   assign bus.EX_PC       = ex_q.pc;

`ifdef ID_EX_BUBBLE_CNT_EN
   logic [15:0] cnt_q;

   // count only load-use bubbles (flush wins over load-use and is not counted); saturate
   always_ff @(posedge clk) begin
      if (!rst)
         cnt_q <= '0;
      else if (!bus.ext_stall && !bus.flush && load_use && cnt_q != 16'hFFFF)
         cnt_q <= cnt_q + 16'd1;
   end

   assign bus.bubble_cnt = cnt_q;
`else
   assign bus.bubble_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   failures = 0;
   int   cnt_exp = 0;

   // control order: {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst}
   localparam logic [5:0] LW  = 6'b110110;
   localparam logic [5:0] ADD = 6'b100001;

   id_ex_stage_if #(.DW(32), .RW(5)) bus ();
   id_ex_stage #(.DW(32), .RW(5)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] bc_exp;
`ifdef ID_EX_BUBBLE_CNT_EN
      return cnt_exp[15:0];
`else
      return 16'h0000;
`endif
   endfunction

   task automatic set_id(input logic v, input logic [4:0] rs, rt, rd, input logic [5:0] ctl,
                         input logic [3:0] op, input logic [31:0] a, b, imm, pc);
      bus.ID_valid = v; bus.ID_Rs = rs; bus.ID_Rt = rt; bus.ID_Rd = rd;
      {bus.ID_RegWrite, bus.ID_MemRead, bus.ID_MemWrite,
       bus.ID_MemtoReg, bus.ID_ALUSrc, bus.ID_RegDst} = ctl;
      bus.ID_ALUOp = op; bus.ID_rs_data = a; bus.ID_rt_data = b;
      bus.ID_imm = imm; bus.ID_PC = pc;
      #1;
   endtask

   task automatic test_reset;
      rst = 0; bus.ext_stall = 0; bus.flush = 0;
      set_id(1'b1, 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom), 4'($urandom),
             $urandom, $urandom, $urandom, $urandom);
      tick;
      set_id(1'b1, 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom), 4'($urandom),
             $urandom, $urandom, $urandom, $urandom);
      tick;
      checks++; if (bus.EX_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0h exp=0", bus.EX_valid); end
      checks++; if (bus.EX_Rs !== 5'd0 || bus.EX_Rt !== 5'd0 || bus.EX_Rd !== 5'd0) begin failures++; $display("FAIL rst_idx got=%0h/%0h/%0h exp=0", bus.EX_Rs, bus.EX_Rt, bus.EX_Rd); end
      checks++; if ({bus.EX_RegWrite, bus.EX_MemRead, bus.EX_MemWrite, bus.EX_MemtoReg, bus.EX_ALUSrc, bus.EX_RegDst, bus.EX_ALUOp} !== 10'd0) begin failures++; $display("FAIL rst_ctl got nonzero exp=0"); end
      checks++; if ({bus.EX_rs_data, bus.EX_rt_data, bus.EX_imm, bus.EX_PC} !== 128'd0) begin failures++; $display("FAIL rst_data got=%0h exp=0", {bus.EX_rs_data, bus.EX_rt_data, bus.EX_imm, bus.EX_PC}); end
      checks++; if (bus.bubble_cnt !== 16'd0) begin failures++; $display("FAIL rst_cnt got=%0h exp=0", bus.bubble_cnt); end
      checks++; if (bus.pc_write !== 1'b1) begin failures++; $display("FAIL rst_pcw got=%0h exp=1", bus.pc_write); end
      rst = 1;
   endtask

   task automatic test_pass_through;
      set_id(1'b1, 5'd3, 5'd4, 5'd9, 6'b100000, 4'h2, 32'h1234, 32'h5678, 32'hFFFF_FFF0, 32'h0000_0104);
      tick;
      checks++; if (bus.EX_Rs !== 5'd3 || bus.EX_Rt !== 5'd4 || bus.EX_Rd !== 5'd9) begin failures++; $display("FAIL pt_idx got=%0h/%0h/%0h exp=3/4/9", bus.EX_Rs, bus.EX_Rt, bus.EX_Rd); end
      checks++; if (bus.EX_RegWrite !== 1'b1 || bus.EX_MemRead !== 1'b0 || bus.EX_ALUOp !== 4'h2) begin failures++; $display("FAIL pt_ctl got rw=%0h mr=%0h op=%0h exp=1/0/2", bus.EX_RegWrite, bus.EX_MemRead, bus.EX_ALUOp); end
      checks++; if (bus.EX_rs_data !== 32'h1234 || bus.EX_rt_data !== 32'h5678) begin failures++; $display("FAIL pt_data got=%0h/%0h exp=1234/5678", bus.EX_rs_data, bus.EX_rt_data); end
      checks++; if (bus.EX_imm !== 32'hFFFF_FFF0 || bus.EX_PC !== 32'h104) begin failures++; $display("FAIL pt_imm_pc got=%0h/%0h exp=fffffff0/104", bus.EX_imm, bus.EX_PC); end
      checks++; if (bus.EX_valid !== 1'b1) begin failures++; $display("FAIL pt_valid got=%0h exp=1", bus.EX_valid); end
   endtask

   task automatic test_load_use;
      set_id(1'b1, 5'd1, 5'd5, 5'd0, LW, 4'h0, 32'h10, 32'h0, 32'h4, 32'h200);
      tick;
      set_id(1'b1, 5'd5, 5'd2, 5'd7, ADD, 4'h2, 32'h0, 32'h22, 32'h0, 32'h204);
      checks++; if (bus.pc_write !== 1'b0 || bus.IF_ID_write !== 1'b0) begin failures++; $display("FAIL lu_hold got=%0h/%0h exp=0/0", bus.pc_write, bus.IF_ID_write); end
      tick; cnt_exp++;
      checks++; if (bus.EX_RegWrite !== 1'b0 || bus.EX_Rs !== 5'd0 || bus.EX_valid !== 1'b0) begin failures++; $display("FAIL lu_bubble got rw=%0h rs=%0h v=%0h exp=0/0/0", bus.EX_RegWrite, bus.EX_Rs, bus.EX_valid); end
      checks++; if (bus.pc_write !== 1'b1 || bus.IF_ID_write !== 1'b1) begin failures++; $display("FAIL lu_release got=%0h/%0h exp=1/1", bus.pc_write, bus.IF_ID_write); end
      checks++; if (bus.bubble_cnt !== bc_exp()) begin failures++; $display("FAIL lu_cnt got=%0h exp=%0h", bus.bubble_cnt, bc_exp()); end
      tick;
      checks++; if (bus.EX_Rs !== 5'd5 || bus.EX_RegWrite !== 1'b1 || bus.EX_rt_data !== 32'h22) begin failures++; $display("FAIL lu_resume got rs=%0h rw=%0h rtd=%0h exp=5/1/22", bus.EX_Rs, bus.EX_RegWrite, bus.EX_rt_data); end
   endtask

   task automatic test_back_to_back;
      set_id(1'b1, 5'd0, 5'd5, 5'd0, LW, 4'h0, 32'h0, 32'h0, 32'h8, 32'h300);
      tick;
      set_id(1'b1, 5'd5, 5'd6, 5'd0, LW, 4'h0, 32'h0, 32'h0, 32'hC, 32'h304);
      checks++; if (bus.pc_write !== 1'b0) begin failures++; $display("FAIL b2b_hold1 got=%0h exp=0", bus.pc_write); end
      tick; cnt_exp++;
      checks++; if (bus.pc_write !== 1'b1 || bus.EX_valid !== 1'b0) begin failures++; $display("FAIL b2b_bubble1 got pcw=%0h v=%0h exp=1/0", bus.pc_write, bus.EX_valid); end
      tick;
      set_id(1'b1, 5'd6, 5'd3, 5'd8, ADD, 4'h2, 32'h0, 32'h0, 32'h0, 32'h308);
      checks++; if (bus.EX_Rt !== 5'd6 || bus.EX_MemRead !== 1'b1 || bus.pc_write !== 1'b0) begin failures++; $display("FAIL b2b_hold2 got rt=%0h mr=%0h pcw=%0h exp=6/1/0", bus.EX_Rt, bus.EX_MemRead, bus.pc_write); end
      tick; cnt_exp++;
      checks++; if (bus.EX_valid !== 1'b0 || bus.pc_write !== 1'b1) begin failures++; $display("FAIL b2b_bubble2 got v=%0h pcw=%0h exp=0/1", bus.EX_valid, bus.pc_write); end
      tick;
      checks++; if (bus.EX_Rs !== 5'd6 || bus.EX_Rd !== 5'd8 || bus.bubble_cnt !== bc_exp()) begin failures++; $display("FAIL b2b_resume got rs=%0h rd=%0h cnt=%0h exp=6/8/%0h", bus.EX_Rs, bus.EX_Rd, bus.bubble_cnt, bc_exp()); end
   endtask

   task automatic test_no_false_stall;
      set_id(1'b1, 5'd1, 5'd0, 5'd0, LW, 4'h0, 32'h0, 32'h0, 32'h0, 32'h400);
      tick;
      set_id(1'b1, 5'd0, 5'd0, 5'd2, ADD, 4'h2, 32'h0, 32'h0, 32'h0, 32'h404);
      checks++; if (bus.pc_write !== 1'b1 || bus.IF_ID_write !== 1'b1) begin failures++; $display("FAIL nfs_rt0 got=%0h/%0h exp=1/1", bus.pc_write, bus.IF_ID_write); end
      tick;
      set_id(1'b1, 5'd1, 5'd6, 5'd0, LW, 4'h0, 32'h0, 32'h0, 32'h0, 32'h408);
      tick;
      set_id(1'b1, 5'd7, 5'd8, 5'd9, ADD, 4'h2, 32'h0, 32'h0, 32'h0, 32'h40C);
      checks++; if (bus.pc_write !== 1'b1) begin failures++; $display("FAIL nfs_nomatch got=%0h exp=1", bus.pc_write); end
      tick;
      checks++; if (bus.EX_Rs !== 5'd7 || bus.EX_valid !== 1'b1 || bus.bubble_cnt !== bc_exp()) begin failures++; $display("FAIL nfs_pass got rs=%0h v=%0h cnt=%0h exp=7/1/%0h", bus.EX_Rs, bus.EX_valid, bus.bubble_cnt, bc_exp()); end
   endtask

   task automatic test_flush_vs_load_use;
      set_id(1'b1, 5'd1, 5'd5, 5'd0, LW, 4'h0, 32'h0, 32'h0, 32'h0, 32'h500);
      tick;
      set_id(1'b1, 5'd5, 5'd2, 5'd3, ADD, 4'h2, 32'h0, 32'h0, 32'h0, 32'h504);
      bus.flush = 1; #1;
      checks++; if (bus.pc_write !== 1'b0) begin failures++; $display("FAIL fl_pcw got=%0h exp=0", bus.pc_write); end
      tick;
      checks++; if (bus.EX_valid !== 1'b0 || bus.EX_Rs !== 5'd0 || bus.EX_RegWrite !== 1'b0) begin failures++; $display("FAIL fl_bubble got v=%0h rs=%0h rw=%0h exp=0/0/0", bus.EX_valid, bus.EX_Rs, bus.EX_RegWrite); end
      checks++; if (bus.bubble_cnt !== bc_exp()) begin failures++; $display("FAIL fl_cnt got=%0h exp=%0h", bus.bubble_cnt, bc_exp()); end
      bus.flush = 0;
   endtask

   task automatic test_ext_stall;
      set_id(1'b1, 5'd3, 5'd4, 5'd5, ADD, 4'h2, 32'hAAAA, 32'hBBBB, 32'h0, 32'h600);
      tick;
      bus.ext_stall = 1; bus.flush = 1;
      for (int i = 0; i < 3; i++) begin
         set_id(1'b1, 5'(10 + i), 5'(20 + i), 5'd1, LW, 4'h1, 32'(i), 32'(i), 32'h0, 32'h700);
         checks++; if (bus.pc_write !== 1'b0 || bus.IF_ID_write !== 1'b0) begin failures++; $display("FAIL es_pcw[%0d] got=%0h/%0h exp=0/0", i, bus.pc_write, bus.IF_ID_write); end
         tick;
         checks++; if (bus.EX_Rs !== 5'd3 || bus.EX_rs_data !== 32'hAAAA || bus.EX_valid !== 1'b1) begin failures++; $display("FAIL es_hold[%0d] got rs=%0h d=%0h v=%0h exp=3/aaaa/1", i, bus.EX_Rs, bus.EX_rs_data, bus.EX_valid); end
      end
      bus.ext_stall = 0; #1;
      tick;
      checks++; if (bus.EX_valid !== 1'b0 || bus.EX_Rs !== 5'd0 || bus.EX_rs_data !== 32'd0) begin failures++; $display("FAIL es_flush got v=%0h rs=%0h d=%0h exp=0/0/0", bus.EX_valid, bus.EX_Rs, bus.EX_rs_data); end
      bus.flush = 0;
      set_id(1'b1, 5'd9, 5'd4, 5'd2, ADD, 4'h3, 32'h99, 32'h0, 32'h0, 32'h800);
      tick;
      checks++; if (bus.EX_Rs !== 5'd9) begin failures++; $display("FAIL es_load got=%0h exp=9", bus.EX_Rs); end
      bus.ext_stall = 1; rst = 0; #1;
      tick; cnt_exp = 0;
      checks++; if (bus.EX_valid !== 1'b0 || bus.EX_Rs !== 5'd0 || bus.EX_rs_data !== 32'd0 || bus.EX_ALUOp !== 4'd0) begin failures++; $display("FAIL es_rst got v=%0h rs=%0h d=%0h op=%0h exp=0", bus.EX_valid, bus.EX_Rs, bus.EX_rs_data, bus.EX_ALUOp); end
      checks++; if (bus.bubble_cnt !== 16'd0) begin failures++; $display("FAIL es_rst_cnt got=%0h exp=0", bus.bubble_cnt); end
      rst = 1; bus.ext_stall = 0;
      tick;
   endtask

   initial begin
      test_reset;
      test_pass_through;
      test_load_use;
      test_back_to_back;
      test_no_false_stall;
      test_flush_vs_load_use;
      test_ext_stall;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage MIPS core, with integrated load-use hazard detection.
- Captures decoded ID-stage control and operands each cycle.
- Presents them as EX_* signals to the EX stage and the forwarding unit.
- Inserts a one-cycle bubble and freezes PC and IF/ID when a load in EX feeds the instruction in ID.

Parameters:
- DW, 32, datapath width (register data, immediate, PC)
- RW, 5, register index width

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-low
- ext_stall  in  1  global freeze (memory busy); holds every register
- flush  in  1  branch/jump taken; kills the instruction entering EX
- ID_valid  in  1  ID holds a real instruction
- ID_Rs, ID_Rt, ID_Rd  in  RW each  decoded register indices
- ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc, ID_RegDst  in  1 each  control
- ID_ALUOp  in  4  ALU operation
- ID_rs_data, ID_rt_data, ID_imm, ID_PC  in  DW each  operands, sign-extended immediate, PC+4
- EX_valid  out  1  EX holds a real instruction
- EX_Rs, EX_Rt, EX_Rd  out  RW each  registered indices (EX_Rs/EX_Rt drive the forwarding unit)
- EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemtoReg, EX_ALUSrc, EX_RegDst  out  1 each
- EX_ALUOp  out  4
- EX_rs_data, EX_rt_data, EX_imm, EX_PC  out  DW each
- pc_write  out  1  0 = PC must hold this cycle (combinational)
- IF_ID_write  out  1  0 = IF/ID must hold this cycle (combinational)
- bubble_cnt  out  16  load-use bubble count (see Optional Feature)

Behaviour:
- All state updates on posedge clk. rst==0 at an edge clears every EX_* output and EX_valid to 0, and clears bubble_cnt; this includes reset mid-stall.
- Hazard detect (combinational): load_use = EX_valid & EX_MemRead & (EX_Rt != 0) & ID_valid & ((EX_Rt == ID_Rs) | (EX_Rt == ID_Rt)).
- pc_write = IF_ID_write = ~(load_use | ext_stall).
- Update priority per edge, highest first:
  1. rst==0: clear all outputs.
  2. ext_stall==1: hold all EX_* values. flush and load_use are ignored. The flush source keeps flush asserted until ext_stall drops.
  3. flush==1: load a bubble.
  4. load_use==1: load a bubble. ID is held upstream, so the same ID instruction is re-presented next cycle.
  5. Otherwise: EX_* <= ID_*, EX_valid <= ID_valid.
- Bubble: all six control bits = 0, EX_ALUOp = 0, EX_Rs/Rt/Rd = 0, data fields = 0, EX_valid = 0.
  - Zeroed indices keep the forwarding unit from matching.
- Latency: ID to EX is 1 cycle.
- A load-use costs exactly 1 bubble: the bubble has MemRead=0, so the hazard cannot re-trigger on the re-presented instruction.
- Back-to-back loads, where a load depends on the previous load, each stall once.
- flush and load_use together: flush wins. pc_write/IF_ID_write still follow the formula; the upstream flush logic overrides them.
- EX_Rt == 0 never causes a stall.

Optional Feature:
- Macro: ID_EX_BUBBLE_CNT_EN.
- Defined:
  - bubble_cnt increments by 1 on each edge that loads a bubble due to load_use (priority level 4 only).
  - Saturates at 16'hFFFF.
  - Cleared by reset.
  - Flush bubbles are not counted.
- Undefined: bubble_cnt is tied to 16'h0000 and no counter flops exist.

Test Plan:
- Reset: hold rst=0 for 2 cycles with random ID inputs -> all EX_* = 0, EX_valid = 0, bubble_cnt = 0, pc_write = 1.
- Pass-through: ID_Rs=3, ID_Rt=4, ID_RegWrite=1, ID_rs_data=32'h1234, ID_valid=1 -> next cycle EX_Rs=3, EX_Rt=4, EX_RegWrite=1, EX_rs_data=32'h1234, EX_valid=1.
- Load-use:
  - Setup: EX holds lw with Rt=5; ID holds add with Rs=5.
  - Required: pc_write=0 and IF_ID_write=0 for exactly 1 cycle.
  - Required: next EX is a bubble (EX_RegWrite=0, EX_Rs=0).
  - Required: the following cycle EX_Rs=5.
  - With macro: bubble_cnt=1.
- No false stall:
  - EX lw Rt=0 with ID Rs=0 -> no stall.
  - EX lw Rt=6 with ID Rs=7, Rt=8 -> no stall.
- Flush vs load-use: load_use condition true and flush=1 -> EX bubble; bubble_cnt unchanged.
- ext_stall:
  - Assert ext_stall for 3 cycles while ID changes and flush=1 -> EX_* unchanged, pc_write=0.
  - After ext_stall drops with flush still 1 -> bubble loaded.
  - Assert rst=0 during the stall -> all cleared at that edge.
